// File: rtl/sram_byte_bridge.sv
// rtl/sram_byte_bridge.sv - two-port 32-bit OBI-style to 8-bit SRAM byte-serialising bridge
//
// Purpose: arbitrates the Ibex instruction and data request ports, serialises each
// granted word access into four little-endian byte slots on the external SRAM pins
// and reassembles read bytes into a 32-bit response word.
//
// Parameters:
//   READ_LATENCY  cycles from a read strobe to valid ext_sram_rdata_i (1..4)
//   ADDR_MASK     ANDed into every ext_sram_addr_o value
//
// Optional feature macro: SRAM_BRIDGE_RR_ARB_EN
//   defined   -> round-robin arbitration between the two ports
//   undefined -> fixed data-over-instr priority
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   instr_req/gnt/rvalid/addr/rdata   instruction port (read only)
//   data_req/gnt/rvalid/we/be/addr/wdata/rdata   data port
//   ext_sram_rdata_i              SRAM read byte
//   ext_sram_wdata_o/addr_o       SRAM write byte and byte address
//   ext_sram_read_o/write_o       one-cycle read / write strobes

module sram_byte_bridge #(
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] ADDR_MASK    = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  input  logic [7:0]  ext_sram_rdata_i,
  output logic [7:0]  ext_sram_wdata_o,
  output logic [31:0] ext_sram_addr_o,
  output logic        ext_sram_read_o,
  output logic        ext_sram_write_o
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              slot_q;
  logic [2:0]              wait_q;
  logic                    owner_q;   // 1 = data port owns the transaction
  logic                    we_q;
  logic [3:0]              be_q;
  logic [31:0]             base_q;
  logic [31:0]             wdata_q;
  logic [23:0]             asm_q;     // bytes 0..2 of the read word, shifted in from the top
  logic [1:0]              cap_q;
  logic [READ_LATENCY-1:0] rd_pipe_q; // read strobes delayed to their capture cycle

  logic        data_first;
  logic        grant;
  logic        gnt_we;
  logic [3:0]  gnt_be;
  logic [31:0] gnt_base;
  logic [1:0]  next_slot;
  logic [31:0] wdata_shift;

`ifdef SRAM_BRIDGE_RR_ARB_EN
  logic last_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_data_q <= 1'b0;
    end else if (grant) begin
      last_data_q <= data_gnt_o;
    end
  end

  // On a tie the port that was not granted last wins.
  assign data_first = ~last_data_q;
`else
  assign data_first = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst_i) begin
          if (data_req_i && (!instr_req_i || data_first)) begin
            data_gnt_o = 1'b1;
          end else if (instr_req_i) begin
            instr_gnt_o = 1'b1;
          end
        end
        if (data_gnt_o || instr_gnt_o) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (slot_q == 2'd3) begin
          state_d = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 3'(READ_LATENCY - 1)) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign grant       = instr_gnt_o | data_gnt_o;
  assign gnt_we      = data_gnt_o & data_we_i;
  assign gnt_be      = data_gnt_o ? data_be_i : 4'hF;
  // Clearing the low bits of the whole address keeps every address bit in use.
  assign gnt_base    = (data_gnt_o ? data_addr_i : instr_addr_i) & 32'hFFFF_FFFC;
  assign next_slot   = slot_q + 2'd1;
  assign wdata_shift = wdata_q >> {next_slot, 3'b000};

  assign instr_rvalid_o = (state_q == RESP) && !owner_q;
  assign data_rvalid_o  = (state_q == RESP) && owner_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q           <= 2'd0;
      wait_q           <= 3'd0;
      owner_q          <= 1'b0;
      we_q             <= 1'b0;
      be_q             <= 4'h0;
      base_q           <= 32'h0;
      wdata_q          <= 32'h0;
      asm_q            <= 24'h0;
      cap_q            <= 2'd0;
      rd_pipe_q        <= '0;
      instr_rdata_o    <= 32'h0;
      data_rdata_o     <= 32'h0;
      ext_sram_addr_o  <= 32'h0;
      ext_sram_wdata_o <= 8'h0;
      ext_sram_read_o  <= 1'b0;
      ext_sram_write_o <= 1'b0;
    end else begin
      ext_sram_read_o  <= 1'b0;
      ext_sram_write_o <= 1'b0;

      // Slot 0 is launched on the grant edge; each XFER cycle launches the next slot.
      if (grant) begin
        owner_q          <= data_gnt_o;
        we_q             <= gnt_we;
        be_q             <= gnt_be;
        base_q           <= gnt_base;
        wdata_q          <= data_wdata_i;
        slot_q           <= 2'd0;
        cap_q            <= 2'd0;
        ext_sram_addr_o  <= gnt_base & ADDR_MASK;
        ext_sram_wdata_o <= data_wdata_i[7:0];
        ext_sram_read_o  <= ~gnt_we;
        ext_sram_write_o <= gnt_we & gnt_be[0];
      end else if (state_q == XFER && slot_q != 2'd3) begin
        slot_q           <= next_slot;
        ext_sram_addr_o  <= (base_q + {30'd0, next_slot}) & ADDR_MASK;
        ext_sram_wdata_o <= wdata_shift[7:0];
        ext_sram_read_o  <= ~we_q;
        ext_sram_write_o <= we_q & be_q[next_slot];
      end

      wait_q <= (state_q == WAIT) ? wait_q + 3'd1 : 3'd0;

      rd_pipe_q[0] <= ext_sram_read_o;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end

      // The fourth byte lands on the edge that enters RESP, so the owner's
      // rdata is loaded straight from the pins together with bytes 0..2.
      if (rd_pipe_q[READ_LATENCY-1]) begin
        cap_q <= cap_q + 2'd1;
        if (cap_q == 2'd3) begin
          if (owner_q) begin
            data_rdata_o <= {ext_sram_rdata_i, asm_q};
          end else begin
            instr_rdata_o <= {ext_sram_rdata_i, asm_q};
          end
        end else begin
          asm_q <= {ext_sram_rdata_i, asm_q[23:8]};
        end
      end
    end
  end

endmodule
